// File: rtl/spi_slave_if.sv
// SPI pin bundle plus the parallel tx/rx side of the SPI mode-3 target.
interface spi_slave_if;
    logic        spi_csn;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [31:0] tx_data;
    logic [5:0]  tx_nbits;
    logic        tx_ack;
    logic [31:0] rx_data;
    logic [5:0]  rx_nbits;
    logic        rx_valid;
    logic        rx_overrun;
    logic        busy;

    modport slave (
        input  spi_csn, spi_sck, spi_mosi, tx_data, tx_nbits,
        output spi_miso, spi_miso_oe, tx_ack, rx_data, rx_nbits,
               rx_valid, rx_overrun, busy
    );

    modport master (
        output spi_csn, spi_sck, spi_mosi, tx_data, tx_nbits,
        input  spi_miso, spi_miso_oe, tx_ack, rx_data, rx_nbits,
               rx_valid, rx_overrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-3 (CPOL=1, CPHA=1) target oversampled on the logic clock.
module spi_slave #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned FLUSH_W = SYNC_STAGES + 1;

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE, DONE} state_t;

    logic [SYNC_STAGES-1:0] csn_sync, sck_sync, mosi_sync;
    logic                   csn_d, sck_d;
    logic [FLUSH_W-1:0]     flush;
    logic                   csn_s, sck_s, mosi_s;
    logic                   csn_rise, sck_rise, sck_fall;

    state_t              state;
    logic [WORD_W-1:0]   tx_shift, rx_shift;
    logic [CNT_W-1:0]    tx_cnt, rx_cnt;
    logic                tx_done, ovf;
    logic                miso_r, oe_r, ack_r, valid_r, overrun_r, busy_r;
    logic [WORD_W-1:0]   rx_data_r;
    logic [CNT_W-1:0]    rx_nbits_r;

    // Pin synchronizers, edge history, and a flush marker so ARM only trusts csn once the pipeline holds real pin values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            csn_sync  <= '1;
            sck_sync  <= '1;
            mosi_sync <= '1;
            csn_d     <= 1'b1;
            sck_d     <= 1'b1;
            flush     <= '0;
        end else begin
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], bus.spi_csn};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            csn_d     <= csn_sync[SYNC_STAGES-1];
            sck_d     <= sck_sync[SYNC_STAGES-1];
            flush     <= {flush[FLUSH_W-2:0], 1'b1};
        end
    end

    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign csn_rise = ~csn_d & csn_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    // Frame FSM with registered outputs; csn_rise beats any sck event in the same cycle.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state      <= ARM;
            tx_shift   <= '0;
            rx_shift   <= '0;
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            tx_done    <= 1'b0;
            ovf        <= 1'b0;
            miso_r     <= 1'b1;
            oe_r       <= 1'b0;
            ack_r      <= 1'b0;
            valid_r    <= 1'b0;
            overrun_r  <= 1'b0;
            busy_r     <= 1'b0;
            rx_data_r  <= '0;
            rx_nbits_r <= '0;
        end else begin
            ack_r   <= 1'b0;
            valid_r <= 1'b0;
            case (state)
                ARM: begin
                    if (flush[FLUSH_W-1] && csn_s) state <= IDLE;
                end
                IDLE: begin
                    // Low csn (not just a fresh fall) starts a frame, so a fall seen during DONE is not lost.
                    if (!csn_s) begin
                        tx_shift <= bus.tx_data << (5'(WORD_W - 1) - bus.tx_nbits[4:0]);
                        tx_cnt   <= bus.tx_nbits;
                        tx_done  <= 1'b0;
                        rx_shift <= '0;
                        rx_cnt   <= '0;
                        ovf      <= 1'b0;
                        ack_r    <= 1'b1;
                        busy_r   <= 1'b1;
                        oe_r     <= 1'b1;
                        miso_r   <= 1'b1;
                        state    <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (csn_rise) begin
                        state <= DONE;
                    end else if (sck_fall) begin
                        if (tx_done) begin
                            miso_r <= 1'b1;
                        end else begin
                            miso_r   <= tx_shift[WORD_W-1];
                            tx_shift <= {tx_shift[WORD_W-2:0], 1'b0};
                            if (tx_cnt == '0) tx_done <= 1'b1;
                            else              tx_cnt  <= tx_cnt - CNT_W'(1);
                        end
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[WORD_W-2:0], mosi_s};
                        if (rx_cnt == CNT_W'(WORD_W)) ovf    <= 1'b1;
                        else                          rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (rx_cnt != '0) begin
                        rx_data_r  <= rx_shift;
                        rx_nbits_r <= rx_cnt - CNT_W'(1);
                        overrun_r  <= ovf;
                        valid_r    <= 1'b1;
                    end
                    busy_r <= 1'b0;
                    oe_r   <= 1'b0;
                    miso_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= ARM;
            endcase
        end
    end

    assign bus.spi_miso    = miso_r;
    assign bus.spi_miso_oe = oe_r;
    assign bus.tx_ack      = ack_r;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_nbits    = rx_nbits_r;
    assign bus.rx_valid    = valid_r;
    assign bus.rx_overrun  = overrun_r;
    assign bus.busy        = busy_r;
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-3 master plus an rx scoreboard.
module tb_spi_slave;
    localparam int HALF = 8;

    typedef struct packed {
        logic [31:0] d;
        logic [5:0]  n;
        logic        o;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2)) dut (.clk_in(clk_in), .rst(rst), .bus(bus));

    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   errors = 0;
    int   rv_cnt = 0;
    int   ack_cnt = 0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each delivered word against the oldest expectation.
    always @(negedge clk_in) begin
        if (!rst && bus.tx_ack) ack_cnt++;
        if (!rst && bus.rx_valid) begin
            rv_cnt++;
            if (q.size() == 0) begin
                chk("rx_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rx_data", 64'(bus.rx_data), 64'(e.d));
                chk("rx_nbits", 64'(bus.rx_nbits), 64'(e.n));
                chk("rx_overrun", 64'(bus.rx_overrun), 64'(e.o));
            end
        end
    end

    // Mode-3 master: drive MOSI on SCK fall, sample MISO just before SCK rise.
    task automatic xfer(input int nb, input logic [63:0] mo, output logic [63:0] mi);
        mi = '0;
        bus.spi_csn = 1'b0;
        repeat (HALF) @(negedge clk_in);
        for (int i = nb - 1; i >= 0; i--) begin
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = mo[i];
            repeat (HALF) @(negedge clk_in);
            mi = {mi[62:0], bus.spi_miso};
            bus.spi_sck = 1'b1;
            repeat (HALF) @(negedge clk_in);
            if (i == nb - 1) begin
                chk("busy_mid", 64'(bus.busy), 64'd1);
                chk("oe_mid", 64'(bus.spi_miso_oe), 64'd1);
            end
        end
        bus.spi_csn = 1'b1;
        repeat (2 * HALF) @(negedge clk_in);
    endtask

    initial begin
        logic [63:0] mi;
        int ack0, rv0, oe_seen, waited;
        bus.spi_csn  = 1'b1;
        bus.spi_sck  = 1'b1;
        bus.spi_mosi = 1'b1;
        bus.tx_data  = '0;
        bus.tx_nbits = '0;
        repeat (4) @(negedge clk_in);
        chk("rst_miso", 64'(bus.spi_miso), 64'd1);
        chk("rst_oe", 64'(bus.spi_miso_oe), 64'd0);
        chk("rst_ack", 64'(bus.tx_ack), 64'd0);
        chk("rst_rx_data", 64'(bus.rx_data), 64'd0);
        chk("rst_rx_nbits", 64'(bus.rx_nbits), 64'd0);
        chk("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
        chk("rst_overrun", 64'(bus.rx_overrun), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk_in);

        // 8-bit loopback
        bus.tx_data = 32'h3C; bus.tx_nbits = 6'd7;
        q.push_back('{d: 32'hA5, n: 6'd7, o: 1'b0});
        xfer(8, 64'hA5, mi);
        chk("miso_8b", mi[7:0], 64'h3C);
        chk("ack_cnt_1", 64'(ack_cnt), 64'd1);
        chk("rv_cnt_1", 64'(rv_cnt), 64'd1);

        // 32-bit frame
        bus.tx_data = 32'h12345678; bus.tx_nbits = 6'd31;
        q.push_back('{d: 32'hDEADBEEF, n: 6'd31, o: 1'b0});
        xfer(32, 64'hDEADBEEF, mi);
        chk("miso_32b", mi[31:0], 64'h12345678);

        // master longer than slave: trailing ones
        bus.tx_data = 32'h81; bus.tx_nbits = 6'd7;
        q.push_back('{d: 32'h0000BEEF, n: 6'd15, o: 1'b0});
        xfer(16, 64'hBEEF, mi);
        chk("miso_mismatch", mi[15:0], 64'h81FF);

        // 34 rises, 1/0 alternating starting with 1: last 32 bits = 0xAAAAAAAA
        bus.tx_data = 32'h0; bus.tx_nbits = 6'd31;
        q.push_back('{d: 32'hAAAAAAAA, n: 6'd31, o: 1'b1});
        xfer(34, 64'h2_AAAA_AAAA, mi);

        // CSN toggle with no SCK: ack but no rx_valid, rx outputs held
        ack0 = ack_cnt; rv0 = rv_cnt;
        bus.spi_csn = 1'b0;
        repeat (20) @(negedge clk_in);
        bus.spi_csn = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("toggle_ack", 64'(ack_cnt), 64'(ack0 + 1));
        chk("toggle_no_valid", 64'(rv_cnt), 64'(rv0));
        chk("hold_rx_data", 64'(bus.rx_data), 64'hAAAAAAAA);
        chk("hold_rx_nbits", 64'(bus.rx_nbits), 64'd31);
        chk("hold_overrun", 64'(bus.rx_overrun), 64'd1);

        // reset after 5 rises, released with CSN low
        rv0 = rv_cnt;
        bus.spi_csn = 1'b0;
        repeat (HALF) @(negedge clk_in);
        for (int i = 0; i < 5; i++) begin
            bus.spi_sck = 1'b0; bus.spi_mosi = i[0];
            repeat (HALF) @(negedge clk_in);
            bus.spi_sck = 1'b1;
            repeat (HALF) @(negedge clk_in);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        oe_seen = 0;
        for (int i = 0; i < 60; i++) begin
            bus.spi_sck = (i % 16) < 8;
            @(negedge clk_in);
            if (bus.spi_miso_oe || bus.busy || bus.tx_ack) oe_seen++;
        end
        chk("arm_no_frame", 64'(oe_seen), 64'd0);
        bus.spi_sck = 1'b1;
        bus.spi_csn = 1'b1;
        repeat (16) @(negedge clk_in);
        chk("rst_no_valid", 64'(rv_cnt), 64'(rv0));
        chk("rst_rx_cleared", 64'(bus.rx_data), 64'd0);
        q.push_back('{d: 32'h5A, n: 6'd7, o: 1'b0});
        xfer(8, 64'h5A, mi);

        waited = 0;
        while (q.size() != 0 && waited < 200) begin
            @(negedge clk_in);
            waited++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("rv_total", 64'(rv_cnt), 64'd5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
